// File: rtl/weights_bank_stream.sv
// ---------------------------------------------------------------------------
// weights_bank_stream
//
// Row-organised weight storage for the CatRecognizer datapath. Each row packs
// WEIGHTS_PER_ROW fixed-point weights of PRECISION bits. The loader writes a
// row at a time with per-lane enables. The MAC array reads back an
// autonomous burst of consecutive rows through a valid/ready stream, one row
// per cycle when the consumer never stalls.
//
// Parameters
//   PRECISION        bits per weight (5, 8 or 16)
//   WEIGHTS_PER_ROW  weights packed per row
//   ADDR_WIDTH       row address width, DEPTH = 2**ADDR_WIDTH
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-low reset
//   wr_en       write strobe
//   wr_addr     write row address
//   wr_data     write row, lane k at [k*PRECISION +: PRECISION]
//   wr_lane_en  per-lane write enable
//   rd_start    burst request (sampled only while idle)
//   rd_addr     burst base row
//   rd_len      burst length in rows, 0..DEPTH (0 is ignored)
//   busy        a burst is in progress
//   rd_valid    rd_data holds a valid row
//   rd_ready    consumer accepts the row
//   rd_data     streamed row
//   rd_last     current row is the final row of the burst
// ---------------------------------------------------------------------------
module weights_bank_stream #(
    parameter int PRECISION       = 8,
    parameter int WEIGHTS_PER_ROW = 3,
    parameter int ADDR_WIDTH      = 12
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   wr_en,
    input  logic [ADDR_WIDTH-1:0]                  wr_addr,
    input  logic [PRECISION*WEIGHTS_PER_ROW-1:0]   wr_data,
    input  logic [WEIGHTS_PER_ROW-1:0]             wr_lane_en,
    input  logic                                   rd_start,
    input  logic [ADDR_WIDTH-1:0]                  rd_addr,
    input  logic [ADDR_WIDTH:0]                    rd_len,
    output logic                                   busy,
    output logic                                   rd_valid,
    input  logic                                   rd_ready,
    output logic [PRECISION*WEIGHTS_PER_ROW-1:0]   rd_data,
    output logic                                   rd_last
);

    localparam int ROW_WIDTH = PRECISION * WEIGHTS_PER_ROW;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   ptr;        // next row to load, wraps modulo DEPTH
    logic [ADDR_WIDTH:0]     remaining;  // rows not yet loaded into rd_data

    logic [ROW_WIDTH-1:0]    mem [DEPTH];

    logic                    load_row;
    logic                    accept_last;

    // -----------------------------------------------------------------------
    // Storage with per-lane write enables.
    // NOTE: the weight array has no reset branch on purpose; a reset term on
    // every storage bit would stop it mapping onto RAM and buys nothing,
    // since the loader always writes a row before it is read.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int k = 0; k < WEIGHTS_PER_ROW; k++) begin
                if (wr_lane_en[k]) begin
                    mem[wr_addr][k*PRECISION +: PRECISION] <= wr_data[k*PRECISION +: PRECISION];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output register refill condition: the register is empty or its row is
    // being taken this cycle, and rows of the burst are still outstanding.
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    // -----------------------------------------------------------------------
    always_comb begin
        load_row    = 1'b0;
        accept_last = 1'b0;
        if (state == STREAM) begin
            load_row    = (!rd_valid || rd_ready) && (remaining != '0);
            accept_last = rd_valid && rd_ready && rd_last;
        end
    end

    // -----------------------------------------------------------------------
    // Burst sequencer and output register.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; in particular mem[ptr] is read before the
    // storage block commits a same-edge write, which gives read-before-write
    // on a collision.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A zero-length request is dropped without leaving IDLE.
                    if (rd_start && (rd_len != '0)) begin
                        ptr       <= rd_addr;
                        remaining <= rd_len;
                        busy      <= 1'b1;
                        state     <= STREAM;
                    end
                end

                STREAM: begin
                    // rd_start is not looked at here: requests during a
                    // burst are discarded, not queued.
                    if (accept_last) begin
                        busy     <= 1'b0;
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        state    <= IDLE;
                    end else if (load_row) begin
                        rd_data   <= mem[ptr];
                        rd_valid  <= 1'b1;
                        rd_last   <= (remaining == (ADDR_WIDTH+1)'(1));
                        ptr       <= ptr + ADDR_WIDTH'(1);
                        remaining <= remaining - (ADDR_WIDTH+1)'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weights_bank_stream.sv
// ---------------------------------------------------------------------------
// Testbench for weights_bank_stream (default parameters: 8-bit weights,
// 3 lanes, 4096 rows). A transaction-level model of the burst stream runs
// alongside the DUT; a negedge process compares every cycle and collects the
// accepted rows, which directed tests then compare against literal values.
// ---------------------------------------------------------------------------
module tb_weights_bank_stream;

    localparam int P     = 8;
    localparam int W     = 3;
    localparam int AW    = 12;
    localparam int RW    = P * W;
    localparam int DEPTH = 2 ** AW;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           wr_en = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [RW-1:0]  wr_data = '0;
    logic [W-1:0]   wr_lane_en = '0;
    logic           rd_start = 1'b0;
    logic [AW-1:0]  rd_addr = '0;
    logic [AW:0]    rd_len = '0;
    logic           busy;
    logic           rd_valid;
    logic           rd_ready = 1'b1;
    logic [RW-1:0]  rd_data;
    logic           rd_last;

    int n_checks = 0;
    int n_errors = 0;

    weights_bank_stream #(
        .PRECISION       (P),
        .WEIGHTS_PER_ROW (W),
        .ADDR_WIDTH      (AW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_lane_en (wr_lane_en),
        .rd_start   (rd_start),
        .rd_addr    (rd_addr),
        .rd_len     (rd_len),
        .busy       (busy),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model: memory image plus the burst seen as "row index i of
    // len, starting at base". Rows are fetched from the image as it stood
    // before any write on the same edge.
    // -----------------------------------------------------------------------
    logic [RW-1:0] mem_model [DEPTH];
    bit            m_busy, m_valid, m_last, accept;
    logic [RW-1:0] m_data;
    int            m_base, m_len, m_sent;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_busy  = 0;
            m_valid = 0;
            m_last  = 0;
            m_sent  = 0;
            m_len   = 0;
        end else begin
            accept = m_valid && rd_ready;
            if (!m_busy) begin
                if (rd_start && rd_len != 0) begin
                    m_busy = 1;
                    m_base = int'(rd_addr);
                    m_len  = int'(rd_len);
                    m_sent = 0;
                end
            end else if (accept && m_last) begin
                m_busy  = 0;
                m_valid = 0;
                m_last  = 0;
            end else if ((!m_valid || accept) && m_sent < m_len) begin
                m_data  = mem_model[(m_base + m_sent) % DEPTH];
                m_last  = (m_sent + 1 == m_len);
                m_valid = 1;
                m_sent++;
            end
            if (wr_en) begin
                for (int k = 0; k < W; k++) begin
                    if (wr_lane_en[k]) mem_model[wr_addr][k*P +: P] = wr_data[k*P +: P];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-cycle compare, stall stability and accepted-row capture.
    // -----------------------------------------------------------------------
    logic [RW-1:0] got_data [$];
    bit            got_last [$];
    bit            prev_stall = 0;
    logic [RW-1:0] prev_data;
    logic          prev_last;

    always @(negedge clock) begin
        if (reset) begin
            check("busy", 64'(busy), 64'(m_busy));
            check("rd_valid", 64'(rd_valid), 64'(m_valid));
            if (m_valid) begin
                check("rd_last", 64'(rd_last), 64'(m_last));
                check("rd_data", 64'(rd_data), 64'(m_data));
            end
            if (prev_stall) begin
                check("stall_data", 64'(rd_data), 64'(prev_data));
                check("stall_last", 64'(rd_last), 64'(prev_last));
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            prev_last  = rd_last;
            if (rd_valid && rd_ready) begin
                got_data.push_back(rd_data);
                got_last.push_back(rd_last);
            end
        end else begin
            prev_stall = 0;
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_row(input int addr, input logic [RW-1:0] data, input logic [W-1:0] lanes);
        wr_en      = 1'b1;
        wr_addr    = AW'(addr);
        wr_data    = data;
        wr_lane_en = lanes;
        tick();
        wr_en      = 1'b0;
    endtask

    // mode 0: rd_ready=1; 1: ready pattern 1,0,0,1,...;
    // 2: ready low for 3 cycles with an extra rd_start while busy;
    // 3: ready=1 plus a write to row 7 on the edge that loads the 2nd row.
    bit b0, v0, v1;
    int cycles;

    task automatic run_burst(input int base, input int len, input int mode);
        got_data.delete();
        got_last.delete();
        rd_addr  = AW'(base);
        rd_len   = (AW+1)'(len);
        rd_start = 1'b1;
        rd_ready = 1'b1;
        tick();
        rd_start = 1'b0;
        b0 = busy;
        v0 = rd_valid;
        v1 = 0;
        cycles = 0;
        while (busy && cycles < 200) begin
            case (mode)
                1:       rd_ready = (cycles % 4 == 0) || (cycles % 4 == 3);
                2:       rd_ready = (cycles >= 3);
                default: rd_ready = 1'b1;
            endcase
            rd_start = (mode == 2 && cycles == 1);
            if (mode == 2 && cycles == 1) begin
                rd_addr = AW'(5);
                rd_len  = (AW+1)'(1);
            end
            if (mode == 3 && cycles == 1) begin
                wr_en      = 1'b1;
                wr_addr    = AW'(7);
                wr_data    = 24'h123456;
                wr_lane_en = 3'b111;
            end
            tick();
            rd_start = 1'b0;
            wr_en    = 1'b0;
            cycles++;
            if (cycles == 1) v1 = rd_valid;
        end
        rd_ready = 1'b1;
        check("burst_timeout", 64'(cycles < 200), 64'd1);
    endtask

    task automatic check_stream(input string name, input logic [RW-1:0] exp[$]);
        check($sformatf("%s_count", name), 64'(got_data.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got_data.size(); i++) begin
            check($sformatf("%s_row%0d", name, i), 64'(got_data[i]), 64'(exp[i]));
            check($sformatf("%s_last%0d", name, i), 64'(got_last[i]), 64'(i == exp.size() - 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    logic [RW-1:0] exp_q [$];

    initial begin
        // Reset state.
        #2 reset = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_last", 64'(rd_last), 64'd0);
        check("rst_data", 64'(rd_data), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Basic burst with latency and throughput checks.
        for (int i = 0; i < 4; i++) write_row(i, RW'(i + 1), 3'b111);
        run_burst(0, 4, 0);
        check("t1_busy_after_e0", 64'(b0), 64'd1);
        check("t1_valid_after_e0", 64'(v0), 64'd0);
        check("t1_valid_after_e1", 64'(v1), 64'd1);
        check("t1_edges_to_done", 64'(cycles), 64'd5);
        exp_q = '{24'h000001, 24'h000002, 24'h000003, 24'h000004};
        check_stream("basic", exp_q);

        // Backpressure.
        run_burst(0, 4, 1);
        check_stream("bp", exp_q);

        // Address wrap across DEPTH-1.
        write_row(4094, 24'h0A0A0A, 3'b111);
        write_row(4095, 24'h0B0B0B, 3'b111);
        write_row(0, 24'h0C0C0C, 3'b111);
        write_row(1, 24'h0D0D0D, 3'b111);
        run_burst(4094, 4, 0);
        exp_q = '{24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C, 24'h0D0D0D};
        check_stream("wrap", exp_q);

        // Lane mask.
        write_row(5, 24'hAABBCC, 3'b111);
        write_row(5, 24'h112233, 3'b010);
        run_burst(5, 1, 0);
        exp_q = '{24'hAA22CC};
        check_stream("lane", exp_q);

        // Collision: row 7 written on the edge it is loaded.
        write_row(6, 24'h666666, 3'b111);
        write_row(7, 24'h777777, 3'b111);
        run_burst(6, 2, 3);
        exp_q = '{24'h666666, 24'h777777};
        check_stream("collide_old", exp_q);
        run_burst(7, 1, 0);
        exp_q = '{24'h123456};
        check_stream("collide_new", exp_q);

        // rd_start while busy is dropped, not queued.
        run_burst(2, 2, 2);
        exp_q = '{24'h000003, 24'h000004};
        check_stream("start_busy", exp_q);
        tick();
        tick();
        check("start_busy_not_queued", 64'(busy), 64'd0);

        // Zero-length request is ignored.
        rd_addr  = AW'(0);
        rd_len   = '0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        check("len0_busy", 64'(busy), 64'd0);
        check("len0_valid", 64'(rd_valid), 64'd0);

        // Mid-burst reset during the 3rd row of an 8-row burst.
        write_row(4, 24'h444444, 3'b111);
        rd_addr  = AW'(0);
        rd_len   = (AW+1)'(8);
        rd_start = 1'b1;
        rd_ready = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        tick();
        tick();
        check("mid_third_row", 64'(rd_data), 64'h000003);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_valid", 64'(rd_valid), 64'd0);
        check("mid_rst_last", 64'(rd_last), 64'd0);
        check("mid_rst_data", 64'(rd_data), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        run_burst(0, 2, 0);
        exp_q = '{24'h0C0C0C, 24'h0D0D0D};
        check_stream("after_rst", exp_q);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/weights_bank_stream.md
# weights_bank_stream

Parametrised weight storage for the CatRecognizer datapath. It holds rows of packed fixed-point weights: `WEIGHTS_PER_ROW` lanes of `PRECISION` bits each. Rows are written one at a time from the AMBA-side loader, with per-lane write enables. Rows are read back as an autonomous burst stream with a valid/ready handshake, so the neuron MAC array receives one row per cycle without re-issuing addresses.

## Interface
- `PRECISION`, default 8: bits per weight; legal values 5, 8, 16.
- `WEIGHTS_PER_ROW`, default 3: weights packed per row.
- `ADDR_WIDTH`, default 12: row address width; DEPTH = 2**ADDR_WIDTH.
- ROW_WIDTH: derived, not overridable; equals PRECISION*WEIGHTS_PER_ROW.

- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  ADDR_WIDTH  write row address.
- `wr_data`  in  ROW_WIDTH  write row; lane k is bits [k*PRECISION +: PRECISION].
- `wr_lane_en`  in  WEIGHTS_PER_ROW  per-lane write enable.
- `rd_start`  in  1  burst request.
- `rd_addr`  in  ADDR_WIDTH  burst base row.
- `rd_len`  in  ADDR_WIDTH+1  burst length in rows, 0..DEPTH.
- `busy`  out  1  a burst is in progress.
- `rd_valid`  out  1  `rd_data` holds a valid row.
- `rd_ready`  in  1  consumer accepts the row.
- `rd_data`  out  ROW_WIDTH  streamed row.
- `rd_last`  out  1  current row is the final row of the burst.

## Operation
- Storage is an array of DEPTH x ROW_WIDTH registers. Reset does not clear it; contents are undefined until written.
- Write: when `wr_en`=1, each lane k with `wr_lane_en[k]`=1 is updated at `wr_addr`. Lanes with the enable at 0 keep their value. Writes are accepted in any state, including during a burst.
- FSM states are IDLE and STREAM.
- IDLE:
  - `rd_start`=1 with `rd_len`≠0 latches base and length, sets remaining = `rd_len`, and moves to STREAM.
  - `rd_start` with `rd_len`=0 is ignored and the block stays in IDLE.
- STREAM: the output register loads row[ptr] whenever it is empty or its row is being accepted (`rd_valid`&`rd_ready`), provided rows remain.
  - Each load advances ptr by 1 modulo DEPTH and decrements remaining.
  - `rd_last`=1 with the row loaded when remaining was 1.
  - The handshake of the `rd_last` row returns the FSM to IDLE.
- `rd_start` while `busy`=1 is ignored. It is not queued.
- Address wrap: a burst crossing DEPTH-1 continues at row 0. `rd_len`=DEPTH reads every row exactly once.
- Read/write collision: a row loaded at the same edge as a write to that row returns the pre-write contents (read-before-write). The new value is visible on any later load.
- `rd_data` and `rd_last` are held stable while `rd_valid`=1 and `rd_ready`=0.

## Timing
- Reset (asynchronous, `reset`=0) forces:
  - FSM to IDLE
  - `busy`=0, `rd_valid`=0, `rd_last`=0
  - `rd_data`=0
  - internal ptr and remaining to 0
- The same values apply when reset is asserted mid-burst. The burst is abandoned, and after release the block accepts a new `rd_start` normally.
- Start latency: with `rd_start` sampled at edge E0:
  - `busy`=1 after E0.
  - The first row is loaded at E1, so `rd_valid`=1 after E1.
- Throughput: with `rd_ready` held at 1, one row per cycle. An N-row burst completes N+1 edges after E0.
- Completion: at the edge where the `rd_last` row handshakes, `busy`, `rd_valid` and `rd_last` all go to 0. A new `rd_start` can be sampled at the next edge.
- Write latency: a write at edge E updates storage at E. A burst load at E+1 or later returns the new data.

## Test plan
- Reset, then write rows 0..3 with values 0x000001..0x000004 (full lane enables). Burst base 0, len 4, `rd_ready`=1 → `rd_valid` rises one cycle after `busy`. Data 1,2,3,4 appear on consecutive cycles; `rd_last` is set only on 4; `busy` drops after the 4th handshake.
- Backpressure: same burst with `rd_ready` toggling 1,0,0,1,… → no row is dropped or duplicated; `rd_data` is stable during every stall.
- Wrap: DEPTH=4096, burst base 4094, len 4 → rows 4094, 4095, 0, 1 in order; `rd_last` is on row 1.
- Lane mask: row 5 = 0xAABBCC, then write 0x112233 with `wr_lane_en`=3'b010 → row 5 reads 0xAA22CC.
- Collision and ignored requests:
  - Write row 7 on the same edge it is loaded → the stream shows the old value; a second burst shows the new value.
  - `rd_start` while busy, or `rd_len`=0 → no effect.
- Mid-burst reset: assert `reset`=0 during the 3rd row of an 8-row burst → all outputs are 0 immediately. After release, a new burst base 0, len 2 streams correctly.
